step_debouncer: RTL and testbench

STEP_DEBOUNCER -- requirements
Module: step_debouncer

---
 rtl/step_debouncer_pkg.sv | 15 +
 rtl/step_debouncer_if.sv | 11 +
 rtl/step_debouncer_channel.sv | 55 +++++
 rtl/step_debouncer.sv | 92 +++++++++
 tb/tb_step_debouncer.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/step_debouncer_pkg.sv
// Shared constants and repeat-FSM encoding for the step debouncer block.
package step_debouncer_pkg;
  localparam int NUM_BTN  = 5;
  localparam int STEP_BTN = 0;

  localparam int DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int DEF_REPEAT_DELAY    = 50000000;
  localparam int DEF_REPEAT_PERIOD   = 20000000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rpt_state_e;
endpackage

// File: rtl/step_debouncer_if.sv
// Button bundle: raw buttons in, debounced levels/presses and step strobe out.
interface step_debouncer_if;
  import step_debouncer_pkg::*;
  logic [NUM_BTN-1:0] btn_in;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_press;
  logic               step;

  modport master (output btn_in, input btn_level, btn_press, step);
  modport slave  (input btn_in, output btn_level, btn_press, step);
endinterface

// File: rtl/step_debouncer_channel.sv
// One button: 2-flop synchronizer, sample register, stability counter, level and press pulse.
module debounce_channel
  import step_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic level_o,
  output logic press_o,
  output logic level_nxt_o,
  output logic press_nxt_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1_q, sync2_q, samp_q;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The level commits on the DEBOUNCE_CYCLES-th consecutive differing sample.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (samp_q != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) level_d = ~level_q;
      else                                   cnt_d   = cnt_q + 1'b1;
    end
    press_d = level_d & ~level_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      samp_q  <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      samp_q  <= sync2_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign level_o     = level_q;
  assign press_o     = press_q;
  assign level_nxt_o = level_d;
  assign press_nxt_o = press_d;
endmodule

// File: rtl/step_debouncer.sv
// Debounces NUM_BTN buttons and derives a single-cycle step strobe, with optional auto-repeat.
module step_debouncer
  import step_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_EN       = 0,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input logic             clk,
  input logic             rst_n,
  step_debouncer_if.slave bus
);
  localparam int TW = $clog2((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);

  logic [NUM_BTN-1:0] level_w, press_w, level_nxt, press_nxt;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
    debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .btn_i       (bus.btn_in[g]),
      .level_o     (level_w[g]),
      .press_o     (press_w[g]),
      .level_nxt_o (level_nxt[g]),
      .press_nxt_o (press_nxt[g])
    );
  end

  // Only the step channel's look-ahead feeds the repeat FSM.
  logic unused_nxt;
  assign unused_nxt = ^{level_nxt, press_nxt};

  rpt_state_e    state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          step_q, step_d;

  // Release is taken from the level's next value so it beats a timer expiry on the same edge.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q + 1'b1;
    step_d  = 1'b0;
    if (!level_nxt[STEP_BTN]) begin
      state_d = ST_IDLE;
      tmr_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          tmr_d = '0;
          if (press_nxt[STEP_BTN]) begin
            state_d = ST_DELAY;
            step_d  = 1'b1;
          end
        end
        ST_DELAY: if (tmr_q == TW'(REPEAT_DELAY - 1)) begin
          state_d = ST_REPEAT;
          tmr_d   = '0;
          step_d  = 1'b1;
        end
        ST_REPEAT: if (tmr_q == TW'(REPEAT_PERIOD - 1)) begin
          tmr_d  = '0;
          step_d = 1'b1;
        end
        default: begin
          state_d = ST_IDLE;
          tmr_d   = '0;
        end
      endcase
    end
    if (REPEAT_EN == 0) begin
      state_d = ST_IDLE;
      tmr_d   = '0;
      step_d  = press_nxt[STEP_BTN];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      tmr_q   <= '0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      step_q  <= step_d;
    end
  end

  assign bus.btn_level = level_w;
  assign bus.btn_press = press_w;
  assign bus.step      = step_q;
endmodule

// File: tb/tb_step_debouncer.sv
// Bench for step_debouncer: one DUT without and one with auto-repeat, checked against a window/age model.
module tb_step_debouncer;
  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] btn = '0;

  always #5 clk = ~clk;

  step_debouncer_if if0 ();
  step_debouncer_if if1 ();
  assign if0.btn_in = btn;
  assign if1.btn_in = btn;

  step_debouncer #(.DEBOUNCE_CYCLES(D), .REPEAT_EN(0), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP))
    u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  step_debouncer #(.DEBOUNCE_CYCLES(D), .REPEAT_EN(1), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP))
    u1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  int n_checks = 0;
  int n_errs   = 0;
  int cyc      = 0;
  int n_p2     = 0;
  int stepq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: level flips once the last D post-reset samples all disagree with it;
  // repeat pulses follow from the number of cycles since the press.
  logic [4:0] m_s1 = '0, m_s2 = '0, m_s3 = '0, m_lvl = '0, m_prs = '0;
  logic       m_step0 = 1'b0, m_step1 = 1'b0;
  logic [4:0] hist[$];
  int         age = 0;

  task automatic model_edge();
    logic [4:0] nxt;
    bit         all_diff;
    if (!rst_n) begin
      m_s1 = '0; m_s2 = '0; m_s3 = '0; m_lvl = '0; m_prs = '0;
      m_step0 = 1'b0; m_step1 = 1'b0; hist.delete(); age = 0;
    end else begin
      hist.push_back(m_s3);
      if (hist.size() > D) void'(hist.pop_front());
      nxt = m_lvl;
      for (int c = 0; c < 5; c++) begin
        all_diff = (hist.size() == D);
        foreach (hist[k]) if (hist[k][c] == m_lvl[c]) all_diff = 1'b0;
        if (all_diff) nxt[c] = ~m_lvl[c];
      end
      m_prs   = nxt & ~m_lvl;
      age     = m_prs[0] ? 0 : age + 1;
      m_step0 = m_prs[0];
      m_step1 = m_prs[0] || (nxt[0] && age >= RD && ((age - RD) % RP) == 0);
      m_lvl   = nxt;
      m_s3 = m_s2; m_s2 = m_s1; m_s1 = btn;
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    model_edge();
  end

  initial forever begin
    @(negedge clk);
    chk("level0", if0.btn_level, m_lvl);
    chk("press0", if0.btn_press, m_prs);
    chk("step0",  if0.step,      m_step0);
    chk("level1", if1.btn_level, m_lvl);
    chk("press1", if1.btn_press, m_prs);
    chk("step1",  if1.step,      m_step1);
    if (if1.step === 1'b1) stepq.push_back(cyc);
    if (if0.btn_press[2] === 1'b1) n_p2++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int p;
    int np;
    int exp_off[6] = '{0, 20, 28, 36, 44, 52};

    tick(3);
    chk("rst_level", if0.btn_level, 5'b0);
    chk("rst_press", if0.btn_press, 5'b0);
    chk("rst_step0", if0.step, 1'b0);
    chk("rst_step1", if1.step, 1'b0);
    rst_n = 1'b1;
    tick(2);

    // Clean press on channel 0, kept held for the auto-repeat run
    btn[0] = 1'b1;
    tick(6);
    chk("clean_lvl_early", if0.btn_level, 5'b00000);
    tick(1);
    chk("clean_lvl",   if0.btn_level, 5'b00001);
    chk("clean_press", if0.btn_press, 5'b00001);
    chk("clean_step0", if0.step, 1'b1);
    chk("clean_step1", if1.step, 1'b1);
    chk("model_lvl",   m_lvl, 5'b00001);
    p = cyc;
    tick(1);
    chk("clean_press_end", if0.btn_press, 5'b0);
    chk("clean_step0_end", if0.step, 1'b0);
    chk("clean_step1_end", if1.step, 1'b0);

    // Release timed so the debounced fall lands on the age-60 repeat expiry
    tick(52);
    btn[0] = 1'b0;
    tick(6);
    chk("race_lvl_held", if1.btn_level[0], 1'b1);
    tick(1);
    chk("race_lvl_fall", if1.btn_level[0], 1'b0);
    chk("race_no_step",  if1.step, 1'b0);
    tick(20);
    chk("repeat_count", stepq.size(), 6);
    for (int i = 0; i < 6 && i < stepq.size(); i++)
      chk("repeat_offset", stepq[i] - p, exp_off[i]);

    // Reset in the middle of repeating with the button held
    btn[0] = 1'b1;
    tick(7);
    chk("rr_press", if1.btn_press, 5'b00001);
    tick(30);
    rst_n = 1'b0;
    tick(1);
    chk("rr_lvl0",  if0.btn_level, 5'b0);
    chk("rr_lvl1",  if1.btn_level, 5'b0);
    chk("rr_press", if1.btn_press, 5'b0);
    chk("rr_step0", if0.step, 1'b0);
    chk("rr_step1", if1.step, 1'b0);
    rst_n = 1'b1;
    tick(6);
    chk("rr_lvl_early", if1.btn_level, 5'b0);
    tick(1);
    chk("rr_fresh_press", if1.btn_press, 5'b00001);
    chk("rr_fresh_step",  if1.step, 1'b1);
    btn = '0;
    tick(12);

    // All buttons at once
    btn = 5'b11111;
    tick(6);
    chk("sim_press_early", if0.btn_press, 5'b0);
    tick(1);
    chk("sim_press", if0.btn_press, 5'b11111);
    chk("sim_level", if0.btn_level, 5'b11111);
    tick(1);
    chk("sim_press_end", if0.btn_press, 5'b0);
    btn = '0;
    tick(12);

    // Bouncing channel 2
    np = n_p2;
    btn[2] = 1'b1; tick(2);
    btn[2] = 1'b0; tick(2);
    btn[2] = 1'b1; tick(2);
    btn[2] = 1'b0; tick(2);
    btn[2] = 1'b1;
    tick(6);
    chk("bounce_lvl_early", if0.btn_level[2], 1'b0);
    tick(1);
    chk("bounce_press", if0.btn_press, 5'b00100);
    tick(5);
    chk("bounce_pulses", n_p2 - np, 1);
    btn = '0;
    tick(12);

    // Random buttons with occasional resets; the compare process does the checking
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 599) != 0);
      for (int c = 0; c < 5; c++)
        if ($urandom_range(0, (c == 0) ? 59 : 7) == 0) btn[c] = ~btn[c];
    end
    rst_n = 1'b1;
    tick(2);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
